// File: rtl/ps2_pkg.sv
// ps2_pkg: types and helpers shared by the PS/2 keyboard transmitter and
// the receiver side (state names, frame length, parity).
package ps2_pkg;

   // Transmitter states; INHIBIT is only reachable with PS2_HOST_INHIBIT_EN.
   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      LOW,
      HIGH,
      GAP,
      INHIBIT
   } ps2_state_e;

   // start + 8 data + parity + stop
   localparam int FRAME_BITS = 11;

   // Odd parity bit for a data byte: set when the byte has an even number of ones.
   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_halfbit_timer.sv
// ps2_halfbit_timer: loadable 16-bit down-counter. Used for both the
// KBD_CLK half-periods and the inter-frame gap. done is high while the
// count sits at zero; doneNext says the count will be zero next cycle,
// which lets the parent produce registered strobes aligned to expiry.
module ps2_halfbit_timer (
   input  logic        clk,
   input  logic        resetn,
   input  logic        load,
   input  logic [15:0] loadVal,
   output logic        done,
   output logic        doneNext
);

   logic [15:0] count;

   // Reload on request, otherwise count down and park at zero.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count <= 16'd0;
      end else if (load) begin
         count <= loadVal;
      end else if (count != 16'd0) begin
         count <= count - 16'd1;
      end
   end

   assign done     = (count == 16'd0);
   assign doneNext = load ? (loadVal == 16'd0) : (count <= 16'd1);

endmodule

// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx: device-side PS/2 keyboard transmitter. Sends one byte per
// handshake as start(0), 8 data bits LSB first, odd parity, stop(1),
// generating KBD_CLK itself. All outputs are registered and computed from
// the next state so they change on the same edge as the state.
// Build option: define PS2_HOST_INHIBIT_EN to add the hostInhibit input,
// which aborts a frame before parity and retransmits it after release.
module ps2_kbd_tx
   import ps2_pkg::*;
#(
   parameter int HALF_CYCLES = 1000,
   parameter int GAP_CYCLES  = 2000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [7:0] dataIn,
   input  logic       dataInValid,
`ifdef PS2_HOST_INHIBIT_EN
   input  logic       hostInhibit,
`endif
   output logic       dataInBusy,
   output logic       frameDone,
   output logic       KBD_CLK,
   output logic       KBD_DATA
);

   localparam logic [15:0] HALF_LOAD  = 16'(HALF_CYCLES - 1);
   localparam logic [15:0] GAP_LOAD   = 16'(GAP_CYCLES - 1);
   localparam logic [3:0]  LAST_BIT   = 4'(FRAME_BITS - 1);
   localparam logic [3:0]  PARITY_BIT = 4'(FRAME_BITS - 2);

   ps2_state_e            state, nextState;
   logic [FRAME_BITS-1:0] shift, shiftNext;
   logic [3:0]            bitCnt, bitCntNext;
   logic                  timerLoad;
   logic [15:0]           timerLoadVal;
   logic                  timerDone;
   logic                  timerDoneNext;
   logic                  inhibitNow;
   logic                  sending;

`ifdef PS2_HOST_INHIBIT_EN
   logic [1:0] inhSync;
   logic [7:0] heldByte, heldByteNext;

   // Two-flop synchroniser for the asynchronous host inhibit line.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         inhSync <= 2'b00;
      end else begin
         inhSync <= {inhSync[0], hostInhibit};
      end
   end

   assign inhibitNow = inhSync[1];
`else
   assign inhibitNow = 1'b0;
`endif

   // One timer serves every phase; it is reloaded on each state change.
   ps2_halfbit_timer uTimer (
      .clk      (clk),
      .resetn   (resetn),
      .load     (timerLoad),
      .loadVal  (timerLoadVal),
      .done     (timerDone),
      .doneNext (timerDoneNext)
   );

   // Next-state, shift register and timer reload decisions.
   always_comb begin
      nextState    = state;
      shiftNext    = shift;
      bitCntNext   = bitCnt;
      timerLoad    = 1'b0;
      timerLoadVal = HALF_LOAD;
`ifdef PS2_HOST_INHIBIT_EN
      heldByteNext = heldByte;
`endif
      case (state)
         IDLE: begin
            if (dataInValid && !dataInBusy && !inhibitNow) begin
               shiftNext  = {1'b1, odd_parity(dataIn), dataIn, 1'b0};
               bitCntNext = 4'd0;
               nextState  = SETUP;
               timerLoad  = 1'b1;
`ifdef PS2_HOST_INHIBIT_EN
               heldByteNext = dataIn;
`endif
            end
         end
         SETUP: begin
            if (timerDone) begin
               nextState = LOW;
               timerLoad = 1'b1;
            end
         end
         LOW: begin
            if (timerDone) begin
               timerLoad = 1'b1;
               if (bitCnt == LAST_BIT) begin
                  nextState    = GAP;
                  timerLoadVal = GAP_LOAD;
               end else begin
                  // Next bit goes out together with the rising KBD_CLK.
                  shiftNext  = {1'b1, shift[FRAME_BITS-1:1]};
                  bitCntNext = bitCnt + 4'd1;
                  nextState  = HIGH;
               end
            end
         end
         HIGH: begin
            if (timerDone) begin
               nextState = LOW;
               timerLoad = 1'b1;
            end
         end
         GAP: begin
            if (timerDone) begin
               nextState = IDLE;
            end
         end
`ifdef PS2_HOST_INHIBIT_EN
         INHIBIT: begin
            // Hold the gap count at full length until the host lets go.
            if (inhibitNow) begin
               timerLoad    = 1'b1;
               timerLoadVal = GAP_LOAD;
            end else if (timerDone) begin
               shiftNext  = {1'b1, odd_parity(heldByte), heldByte, 1'b0};
               bitCntNext = 4'd0;
               nextState  = SETUP;
               timerLoad  = 1'b1;
            end
         end
`endif
         default: begin
            nextState = IDLE;
         end
      endcase
`ifdef PS2_HOST_INHIBIT_EN
      // Before parity leaves, the host may cancel the frame; once parity
      // is on the wire the frame is allowed to finish.
      if ((state == SETUP || state == LOW || state == HIGH) &&
          bitCnt < PARITY_BIT && inhibitNow) begin
         nextState    = INHIBIT;
         shiftNext    = shift;
         bitCntNext   = bitCnt;
         timerLoad    = 1'b1;
         timerLoadVal = GAP_LOAD;
      end
`endif
   end

   assign sending = (nextState == SETUP) || (nextState == LOW) || (nextState == HIGH);

   // State and registered outputs; outputs follow the next state so the
   // lines change on the same edge the state does.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         shift      <= '1;
         bitCnt     <= 4'd0;
         KBD_CLK    <= 1'b1;
         KBD_DATA   <= 1'b1;
         dataInBusy <= 1'b0;
         frameDone  <= 1'b0;
      end else begin
         state      <= nextState;
         shift      <= shiftNext;
         bitCnt     <= bitCntNext;
         KBD_CLK    <= (nextState != LOW);
         KBD_DATA   <= sending ? shiftNext[0] : 1'b1;
         dataInBusy <= (nextState != IDLE) || inhibitNow;
         frameDone  <= (nextState == GAP) && timerDoneNext;
      end
   end

`ifdef PS2_HOST_INHIBIT_EN
   // Byte kept for retransmission after an inhibit abort.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         heldByte <= 8'd0;
      end else begin
         heldByte <= heldByteNext;
      end
   end
`endif

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// tb_ps2_kbd_tx: randomized bench for ps2_kbd_tx (HALF_CYCLES=4, GAP_CYCLES=8).
// Reference: an accept/timing model computed from frame arithmetic plus a
// line-level receiver that decodes frames on KBD_CLK falling edges.
module tb_ps2_kbd_tx;

   localparam int H     = 4;
   localparam int G     = 8;
   localparam int FRAME = 22 * H + G;
   localparam int LIM   = 1000;

   logic       clk = 1'b0;
   logic       resetn;
   logic [7:0] dataIn;
   logic       dataInValid;
   logic       dataInBusy;
   logic       frameDone;
   logic       KBD_CLK;
   logic       KBD_DATA;
`ifdef PS2_HOST_INHIBIT_EN
   logic       hostInhibit;
`endif

   ps2_kbd_tx #(.HALF_CYCLES(H), .GAP_CYCLES(G)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .dataIn      (dataIn),
      .dataInValid (dataInValid),
`ifdef PS2_HOST_INHIBIT_EN
      .hostInhibit (hostInhibit),
`endif
      .dataInBusy  (dataInBusy),
      .frameDone   (frameDone),
      .KBD_CLK     (KBD_CLK),
      .KBD_DATA    (KBD_DATA)
   );

   always #5 clk = ~clk;

   int errCnt = 0;
   int chkCnt = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chkCnt++;
      if (got !== exp) begin
         errCnt++;
         $display("FAIL %s: got %0h expected %0h at cycle", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int         cyc = 0;
   int         freeAt = 0;
   int         busyFrom = 0;
   int         doneAt = -1;
   int         lastAcc = 0;
   int         acceptCnt = 0;
   bit         modelOn = 1'b1;
   logic [7:0] expQ[$];
   int         edgeQ[$];

   // Accept rule: a request is taken on any cycle the previous frame's
   // 1+22H+G window has elapsed; edges and frameDone follow by arithmetic.
   always @(posedge clk) begin
      if (!resetn) begin
         expQ.delete();
         edgeQ.delete();
         freeAt   = 0;
         busyFrom = 0;
         doneAt   = -1;
      end else if (modelOn && dataInValid && cyc >= freeAt) begin
         expQ.push_back(dataIn);
         lastAcc  = cyc;
         acceptCnt++;
         busyFrom = cyc + 1;
         freeAt   = cyc + 1 + FRAME;
         doneAt   = cyc + FRAME;
         for (int k = 0; k < 11; k++) edgeQ.push_back(cyc + 1 + H + 2 * H * k);
      end
      cyc = cyc + 1;
   end

   // ---------------- line monitor / receiver ----------------
   logic        bits[$];
   logic        prevClk = 1'b1;
   logic        prevData = 1'b1;
   int          highRun = 0;
   int          fallCnt = 0;
   int          doneCnt = 0;
   int          frameCnt = 0;
   int          doneSeenCyc = 0;
   int          lastFallCyc = 0;
   int          expE;
   logic [10:0] fr;
   logic [10:0] lastFrame = '0;
   logic [7:0]  rb;
   logic [31:0] expB;
   logic        mBusy;

   always @(negedge clk) begin
      if (!resetn) begin
         bits.delete();
         prevClk  = 1'b1;
         prevData = 1'b1;
         highRun  = 0;
      end else begin
         if (frameDone) begin
            doneCnt++;
            doneSeenCyc = cyc;
         end
         if (modelOn) begin
            mBusy = (cyc >= busyFrom) && (cyc < freeAt);
            chk("busy", 32'(dataInBusy), 32'(mBusy));
            chk("frameDone", 32'(frameDone), 32'(cyc == doneAt));
            if (!mBusy) begin
               chk("idle_clk", 32'(KBD_CLK), 32'd1);
               chk("idle_data", 32'(KBD_DATA), 32'd1);
            end
         end
         if (prevClk && !KBD_CLK) begin
            fallCnt++;
            lastFallCyc = cyc;
            chk("data_hold", 32'(KBD_DATA), 32'(prevData));
            if (modelOn) begin
               expE = (edgeQ.size() > 0) ? edgeQ.pop_front() : -1;
               chk("edge_cyc", 32'(cyc), 32'(expE));
            end
            bits.push_back(KBD_DATA);
            if (bits.size() == 11) begin
               for (int i = 0; i < 11; i++) fr[i] = bits[i];
               rb = fr[8:1];
               lastFrame = fr;
               frameCnt++;
               chk("start", 32'(fr[0]), 32'd0);
               chk("stop", 32'(fr[10]), 32'd1);
               chk("parity", 32'(fr[9]), 32'(($countones(rb) % 2) == 0));
               expB = (expQ.size() > 0) ? 32'(expQ.pop_front()) : 32'h100;
               chk("byte", 32'(rb), expB);
               bits.delete();
            end
         end
         // A high stretch longer than one half-period means no frame is in flight.
         highRun = KBD_CLK ? highRun + 1 : 0;
         if (highRun > H) bits.delete();
         prevClk  = KBD_CLK;
         prevData = KBD_DATA;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic sendByte(input logic [7:0] b);
      int k = 0;
      while (cyc < freeAt && k < LIM) begin tick(); k++; end
      chk("send_to", 32'(k < LIM), 32'd1);
      dataIn      = b;
      dataInValid = 1'b1;
      tick();
      dataInValid = 1'b0;
      dataIn      = 8'($urandom);
   endtask

   task automatic waitIdle();
      int k = 0;
      while (cyc <= freeAt && k < LIM) begin tick(); k++; end
      chk("idle_to", 32'(k < LIM), 32'd1);
   endtask

   task automatic waitFrames(input int n);
      int k = 0;
      while (frameCnt < n && k < LIM) begin tick(); k++; end
      chk("frame_to", 32'(k < LIM), 32'd1);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   int a0, d0, f0, f1, n0, rel, k;

   initial begin
      resetn      = 1'b0;
      dataIn      = 8'd0;
      dataInValid = 1'b0;
`ifdef PS2_HOST_INHIBIT_EN
      hostInhibit = 1'b0;
`endif
      repeat (3) tick();
      chk("rst_clk", 32'(KBD_CLK), 32'd1);
      chk("rst_data", 32'(KBD_DATA), 32'd1);
      chk("rst_busy", 32'(dataInBusy), 32'd0);
      chk("rst_done", 32'(frameDone), 32'd0);
      resetn = 1'b1;
      tick();

      // Reset in the middle of a frame drops it without frameDone.
      sendByte(8'h1C);
      repeat (30) tick();
      resetn = 1'b0;
      #1;
      chk("midrst_clk", 32'(KBD_CLK), 32'd1);
      chk("midrst_data", 32'(KBD_DATA), 32'd1);
      chk("midrst_busy", 32'(dataInBusy), 32'd0);
      repeat (3) tick();
      resetn = 1'b1;
      d0 = doneCnt;
      repeat (20) tick();
      chk("post_clk", 32'(KBD_CLK), 32'd1);
      chk("post_data", 32'(KBD_DATA), 32'd1);
      chk("post_busy", 32'(dataInBusy), 32'd0);
      chk("post_nodone", 32'(doneCnt - d0), 32'd0);

      // 0x1C: bit sequence 0,0,0,1,1,1,0,0,0,0,1 and 97-cycle frame.
      n0 = frameCnt;
      sendByte(8'h1C);
      waitFrames(n0 + 1);
      chk("bits_1C", 32'(lastFrame), 32'h438);
      waitIdle();
      chk("done_lat", 32'(doneSeenCyc - lastAcc + 1), 32'(1 + FRAME));

      // 0x00 then 0xFF with valid held; dataIn changes after accept are ignored.
      a0 = acceptCnt;
      n0 = frameCnt;
      dataIn      = 8'h00;
      dataInValid = 1'b1;
      k = 0;
      while (acceptCnt < a0 + 1 && k < LIM) begin tick(); k++; end
      repeat (5) tick();
      dataIn = 8'hFF;
      while (acceptCnt < a0 + 2 && k < LIM) begin tick(); k++; end
      chk("hold_to", 32'(k < LIM), 32'd1);
      dataInValid = 1'b0;
      waitFrames(n0 + 1);
      chk("bits_00", 32'(lastFrame), 32'h600);
      waitFrames(n0 + 2);
      chk("bits_FF", 32'(lastFrame), 32'h7FE);
      waitIdle();

      // A request during a frame is dropped.
      a0 = acceptCnt;
      n0 = frameCnt;
      sendByte(8'h1C);
      repeat (9) tick();
      dataIn      = 8'h55;
      dataInValid = 1'b1;
      tick();
      dataInValid = 1'b0;
      waitIdle();
      repeat (3) tick();
      chk("ign_frames", 32'(frameCnt - n0), 32'd1);
      chk("ign_byte", 32'(lastFrame[8:1]), 32'h1C);

      // Random bytes, random spacing, random stray requests.
      for (int i = 0; i < 16; i++) begin
         repeat ($urandom_range(0, 3)) tick();
         sendByte(8'($urandom));
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 110)) tick();
            dataIn      = 8'($urandom);
            dataInValid = 1'b1;
            tick();
            dataInValid = 1'b0;
         end
      end
      waitIdle();

`ifdef PS2_HOST_INHIBIT_EN
      // Inhibit at falling edge 4 of 0xAA: abort, then full retransmission.
      repeat (4) tick();
      modelOn = 1'b0;
      expQ.push_back(8'hAA);
      f0 = fallCnt;
      d0 = doneCnt;
      n0 = frameCnt;
      dataIn      = 8'hAA;
      dataInValid = 1'b1;
      tick();
      dataInValid = 1'b0;
      k = 0;
      while (fallCnt < f0 + 4 && k < LIM) begin tick(); k++; end
      chk("inh_edge_to", 32'(k < LIM), 32'd1);
      hostInhibit = 1'b1;
      repeat (3) tick();
      chk("inh_clk", 32'(KBD_CLK), 32'd1);
      chk("inh_data", 32'(KBD_DATA), 32'd1);
      repeat (10) tick();
      chk("inh_hold", 32'({KBD_CLK, KBD_DATA}), 32'd3);
      chk("inh_busy", 32'(dataInBusy), 32'd1);
      f1  = fallCnt;
      rel = cyc;
      hostInhibit = 1'b0;
      k = 0;
      while (fallCnt == f1 && k < LIM) begin tick(); k++; end
      chk("inh_gap", 32'((lastFallCyc - rel) >= G + H), 32'd1);
      k = 0;
      while (doneCnt == d0 && k < LIM) begin tick(); k++; end
      chk("inh_done_to", 32'(k < LIM), 32'd1);
      repeat (G + 4) tick();
      chk("inh_done_cnt", 32'(doneCnt - d0), 32'd1);
      chk("inh_frames", 32'(frameCnt - n0), 32'd1);
      chk("inh_edges", 32'(fallCnt - f1), 32'd11);
      chk("inh_byte", 32'(lastFrame[8:1]), 32'hAA);
      modelOn = 1'b1;
`endif

      repeat (10) tick();
      chk("expQ_empty", 32'(expQ.size()), 32'd0);
      chk("edgeQ_empty", 32'(edgeQ.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
      $finish;
   end

endmodule
